pmem_responder: RTL and testbench

- Memory-side responder for the cache's physical-memory line interface (pmem_*): accepts one 128-bit line read or write at a time.
- Models a fixed, parameterised access latency and holds the line contents in a small on-chip array.
- Sits opposite the cache in place of off-chip memory; used as the synthesizable backing store for system-level runs.

---
 rtl/pmem_responder_pkg.sv | 27 ++
 rtl/pmem_responder_if.sv | 33 +++
 rtl/pmem_line_array.sv | 44 ++++
 rtl/pmem_responder.sv | 115 +++++++++++
 tb/tb_pmem_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared types and constants for the physical-memory line responder.
package pmem_responder_pkg;

    localparam int unsigned PMEM_OFFSET_BITS = 4;
    localparam int unsigned PMEM_ADDR_BITS   = 16;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } lc3b_pmem_state;

    typedef enum logic {
        OpRead,
        OpWrite
    } lc3b_pmem_op;

    // Byte address to line number; the caller keeps only the index bits it needs.
    function automatic logic [PMEM_ADDR_BITS-1:0] pmem_line_num(
        input logic [PMEM_ADDR_BITS-1:0] addr
    );
        return addr >> PMEM_OFFSET_BITS;
    endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// Cache-to-memory line interface; the cache drives requests, memory drives responses.
interface pmem_responder_if;
    import pmem_responder_pkg::*;

    logic                      pmem_read;
    logic                      pmem_write;
    logic [PMEM_ADDR_BITS-1:0] pmem_address;
    lc3b_line                  pmem_wdata;
    logic                      pmem_resp;
    lc3b_line                  pmem_rdata;
    logic                      protocol_err;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_resp,
        input  pmem_rdata,
        input  protocol_err
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_resp,
        output pmem_rdata,
        output protocol_err
    );

endinterface

// File: rtl/pmem_line_array.sv
// Line storage: reset-to-zero array, one synchronous write port, registered read port.
module pmem_line_array
    import pmem_responder_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] waddr_i,
    input  lc3b_line              wdata_i,
    input  logic                  re_i,
    input  logic [INDEX_BITS-1:0] raddr_i,
    output lc3b_line              rdata_o
);

    localparam int unsigned Lines = 1 << INDEX_BITS;

    lc3b_line mem_q [Lines];
    lc3b_line rdata_q;

    // Array contents: cleared by reset, single write port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Lines; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds the last line read until the next read enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line memory responder sitting opposite the cache's pmem port.
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned INDEX_BITS = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    pmem_responder_if.slave pmem
);

    localparam logic [3:0] LatLoad = 4'(LATENCY - 1);

    lc3b_pmem_state        state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    lc3b_pmem_op           op_q, op_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  resp_q, resp_d;
    logic                  rd_en, wr_en;
    logic                  req_any, req_held;
    logic [PMEM_ADDR_BITS-1:0] line_num;
    logic [INDEX_BITS-1:0] req_idx;
    logic                  unused_line;

    // Upper line-number bits alias onto the array and are deliberately dropped.
    assign line_num    = pmem_line_num(pmem.pmem_address);
    assign req_idx     = line_num[INDEX_BITS-1:0];
    assign unused_line = ^line_num;

    assign req_any  = pmem.pmem_read | pmem.pmem_write;
    // Only the request that started the transaction keeps it alive.
    assign req_held = (op_q == OpWrite) ? pmem.pmem_write : pmem.pmem_read;

    // State, counter, latched request and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpRead;
            idx_q   <= '0;
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            resp_q  <= resp_d;
        end
    end

    // Next-state: accept in idle, count down or abort in busy, single response cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    // Both requests high is illegal; the write wins.
                    op_d    = pmem.pmem_write ? OpWrite : OpRead;
                    idx_d   = req_idx;
                    cnt_d   = LatLoad;
                    err_d   = err_q | (pmem.pmem_read & pmem.pmem_write);
                    state_d = (LATENCY == 1) ? StResp : StBusy;
                end
            end
            StBusy: begin
                if (!req_held) begin
                    state_d = StIdle;
                end else if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: response pulse and read data are registered on entry to the response cycle;
    // write data is taken from the response cycle itself.
    always_comb begin
        resp_d = (state_d == StResp);
        rd_en  = (state_d == StResp) && (op_d == OpRead);
        wr_en  = (state_q == StResp) && (op_q == OpWrite);
    end

    pmem_line_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .we_i    (wr_en),
        .waddr_i (idx_q),
        .wdata_i (pmem.pmem_wdata),
        .re_i    (rd_en),
        .raddr_i (idx_d),
        .rdata_o (pmem.pmem_rdata)
    );

    assign pmem.pmem_resp    = resp_q;
    assign pmem.protocol_err = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: random and directed line transactions.
module tb_pmem_responder;
    import pmem_responder_pkg::*;

    localparam int unsigned LAT    = 4;
    localparam int unsigned IB     = 5;
    localparam int unsigned NLINES = 32;

    typedef struct {
        int       cyc;
        bit       is_read;
        lc3b_line data;
        bit       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pmem_responder_if bus ();
    pmem_responder_if bus1 ();

    pmem_responder #(.LATENCY(LAT), .INDEX_BITS(IB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pmem  (bus)
    );

    pmem_responder #(.LATENCY(1), .INDEX_BITS(IB)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .pmem  (bus1)
    );

    exp_t     sb [$];
    lc3b_line mem_model [NLINES];
    lc3b_line last_rd;
    bit       err_model;
    int       checks   = 0;
    int       errors   = 0;
    int       cyc      = 0;
    int       resp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic lc3b_line rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NLINES; i++) mem_model[i] = '0;
        last_rd   = '0;
        err_model = 1'b0;
    endfunction

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.pmem_resp === 1'b1) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp cycle=%0d required=none", cyc);
            end else begin
                e = sb.pop_front();
                check("resp_cycle", 128'(cyc), 128'(e.cyc));
                if (e.is_read) check("read_data", bus.pmem_rdata, e.data);
                check("resp_protocol_err", 128'(bus.protocol_err), 128'(e.err));
            end
        end
    end

    // One transaction on the LAT port; drop_after>0 drops the request that many cycles in.
    task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                       input lc3b_line data, input int drop_after);
        int   start;
        int   cnt0;
        int   idx;
        bit   done;
        exp_t e;
        idx = (int'(addr) / 16) % NLINES;
        @(posedge clk); #1;
        bus.pmem_read    = rd;
        bus.pmem_write   = wr;
        bus.pmem_address = addr;
        bus.pmem_wdata   = rand_line();
        start = cyc;
        cnt0  = resp_cnt;
        done  = 1'b0;
        if (rd && wr) err_model = 1'b1;
        if (drop_after == 0) begin
            e.cyc     = start + int'(LAT);
            e.is_read = rd && !wr;
            e.err     = err_model;
            e.data    = '0;
            if (wr) begin
                mem_model[idx] = data;
            end else begin
                e.data  = mem_model[idx];
                last_rd = e.data;
            end
            sb.push_back(e);
        end
        for (int i = 1; i <= int'(LAT) + 4; i++) begin
            @(posedge clk); #1;
            if (drop_after != 0) begin
                if (i == drop_after) begin
                    bus.pmem_read  = 1'b0;
                    bus.pmem_write = 1'b0;
                end
            end else if (resp_cnt != cnt0) begin
                done = 1'b1;
                break;
            end
            // Address is scrambled while busy; write data is only correct in the response cycle.
            bus.pmem_address = 16'($urandom);
            bus.pmem_wdata   = (cyc == start + int'(LAT)) ? data : rand_line();
        end
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        if (drop_after != 0) begin
            check("abort_no_resp", 128'(resp_cnt), 128'(cnt0));
        end else if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=none required=cycle %0d", start + int'(LAT));
            sb.delete();
        end
        check("rdata_hold", bus.pmem_rdata, last_rd);
        check("protocol_err", 128'(bus.protocol_err), 128'(err_model));
    endtask

    // One transaction on the single-cycle-latency instance.
    task automatic txn1(input bit wr, input logic [15:0] addr, input lc3b_line data,
                        input lc3b_line exp_rd);
        int start;
        bit seen;
        @(posedge clk); #1;
        bus1.pmem_read    = !wr;
        bus1.pmem_write   = wr;
        bus1.pmem_address = addr;
        bus1.pmem_wdata   = data;
        start = cyc;
        seen  = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (bus1.pmem_resp === 1'b1) begin
                seen = 1'b1;
                check("l1_resp_cycle", 128'(cyc), 128'(start + 1));
                if (!wr) check("l1_read_data", bus1.pmem_rdata, exp_rd);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL l1_resp_timeout actual=none required=cycle %0d", start + 1);
        end
        @(posedge clk); #1;
        bus1.pmem_read  = 1'b0;
        bus1.pmem_write = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        lc3b_line d_a;
        lc3b_line d_b;
        lc3b_line d_c;
        lc3b_line d_x;
        int       cnt0;
        int       op;
        rst_n             = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_address  = '0;
        bus.pmem_wdata    = '0;
        bus1.pmem_read    = 1'b0;
        bus1.pmem_write   = 1'b0;
        bus1.pmem_address = '0;
        bus1.pmem_wdata   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_resp", 128'(bus.pmem_resp), 128'(0));
        check("reset_rdata", bus.pmem_rdata, '0);
        check("reset_err", 128'(bus.protocol_err), 128'(0));

        // Basic read of an untouched line.
        txn(1'b1, 1'b0, 16'h0040, '0, 0);
        // Write then read with differing offset bits.
        txn(1'b0, 1'b1, 16'h0123, 128'hDEADBEEF_0000_1111_2222_3333_4444_5555, 0);
        txn(1'b1, 1'b0, 16'h0120, '0, 0);
        // Aliasing above the index bits.
        d_a = rand_line();
        txn(1'b0, 1'b1, 16'h0210, d_a, 0);
        txn(1'b1, 1'b0, 16'h0010, '0, 0);
        // Abort then a normal write and read-back.
        txn(1'b1, 1'b0, 16'h0040, '0, 2);
        d_c = rand_line();
        txn(1'b0, 1'b1, 16'h0040, d_c, 0);
        txn(1'b1, 1'b0, 16'h0040, '0, 0);
        // Both requests high: flagged, treated as a write.
        d_b = rand_line();
        txn(1'b1, 1'b1, 16'h0080, d_b, 0);
        txn(1'b1, 1'b0, 16'h0080, '0, 0);

        // Random mix of reads, writes, aborts and illegal encodings.
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            if (op < 4) txn(1'b1, 1'b0, 16'($urandom), '0, 0);
            else if (op < 8) txn(1'b0, 1'b1, 16'($urandom), rand_line(), 0);
            else if (op == 8) txn(1'($urandom), 1'b1, 16'($urandom), rand_line(),
                                  int'($urandom_range(1, LAT - 1)));
            else txn(1'b1, 1'b1, 16'($urandom), rand_line(), 0);
        end

        // Single-cycle latency instance.
        d_x = rand_line();
        txn1(1'b0, 16'h0040, '0, '0);
        txn1(1'b1, 16'h0050, d_x, '0);
        txn1(1'b0, 16'h0058, '0, d_x);

        // Reset while busy: no pulse, array and outputs cleared.
        @(posedge clk); #1;
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 16'h0120;
        cnt0 = resp_cnt;
        repeat (2) @(posedge clk);
        #3;
        rst_n         = 1'b0;
        bus.pmem_read = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("reset_busy_no_resp", 128'(resp_cnt), 128'(cnt0));
        check("reset_busy_rdata", bus.pmem_rdata, '0);
        check("reset_busy_err", 128'(bus.protocol_err), 128'(0));
        txn(1'b1, 1'b0, 16'h0120, '0, 0);
        txn(1'b1, 1'b0, 16'h0040, '0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
